// File: rtl/hqm_aw_async_data_sched_pkg.sv
// Shared types and constants for the async-data crossing scheduler.
package hqm_aw_async_data_sched_pkg;

  typedef enum logic [1:0] {
    ASD_IDLE  = 2'd0,
    ASD_ISSUE = 2'd1,
    ASD_GUARD = 2'd2
  } aw_async_sched_state_t;

  // Shortest guard interval; a programmed 0 is raised to this.
  localparam int ASD_GUARD_MIN = 1;

endpackage

// File: rtl/hqm_aw_async_data_sched_rr_arb.sv
// Combinational round-robin pick: first set bit of req at or above ptr, wrapping.
module hqm_aw_async_data_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_v,
  output logic [IDX_W-1:0]   gnt_idx
);

  int w_j;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    w_j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = int'(ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (req[IDX_W'(w_j)]) begin
        gnt_v   = 1'b1;
        gnt_idx = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/hqm_aw_async_data_sched.sv
// Shares one async data crossing among NUM_REQ requesters: capture, round-robin
// issue as a single xfer_v pulse, then hold off for a guard interval.
module hqm_aw_async_data_sched
  import hqm_aw_async_data_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int GUARD_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [GUARD_W-1:0]       cfg_guard_cycles,
  input  logic [NUM_REQ-1:0]       req_v,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_pend,
  output logic [NUM_REQ-1:0]       req_drop,
  output logic                     xfer_v,
  output logic [IDX_W-1:0]         xfer_idx,
  output logic [WIDTH-1:0]         xfer_data,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE  = ASD_IDLE;
  localparam logic [1:0] ST_ISSUE = ASD_ISSUE;
  localparam logic [1:0] ST_GUARD = ASD_GUARD;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_xfer_idx;
  logic [WIDTH-1:0]   r_xfer_data;
  logic [GUARD_W-1:0] r_guard_cnt;
  logic [NUM_REQ-1:0] r_pend;
  logic [NUM_REQ-1:0] r_drop;
  logic [WIDTH-1:0]   r_hold [NUM_REQ];

  logic               w_gnt_v;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_grant;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [GUARD_W-1:0] w_guard_load;
  logic [IDX_W-1:0]   w_next_ptr;

  hqm_aw_async_data_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req     (r_pend),
    .ptr     (r_rr_ptr),
    .gnt_v   (w_gnt_v),
    .gnt_idx (w_gnt_idx)
  );

  assign w_grant      = (r_state == ST_IDLE) && w_gnt_v;
  assign w_guard_load = (cfg_guard_cycles < GUARD_W'(ASD_GUARD_MIN)) ?
                        GUARD_W'(ASD_GUARD_MIN) : cfg_guard_cycles;
  assign w_next_ptr   = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i] = w_grant && (w_gnt_idx == IDX_W'(i));
    end
  end

  // A new write always wins over the grant clearing pend; the grant reads the old hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_drop <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_v[i]) begin
          r_hold[i] <= req_data[i*WIDTH +: WIDTH];
          r_pend[i] <= 1'b1;
        end else if (w_gnt_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
        r_drop[i] <= req_v[i] && r_pend[i] && !w_gnt_oh[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_xfer_idx  <= '0;
      r_xfer_data <= '0;
      r_guard_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_xfer_idx  <= w_gnt_idx;
            r_xfer_data <= r_hold[w_gnt_idx];
            r_rr_ptr    <= w_next_ptr;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_guard_cnt <= w_guard_load;
          r_state     <= ST_GUARD;
        end
        ST_GUARD: begin
          r_guard_cnt <= r_guard_cnt - 1'b1;
          if (r_guard_cnt <= GUARD_W'(ASD_GUARD_MIN)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_pend  = r_pend;
  assign req_drop  = r_drop;
  assign xfer_v    = (r_state == ST_ISSUE);
  assign xfer_idx  = r_xfer_idx;
  assign xfer_data = r_xfer_data;
  assign busy      = (r_state != ST_IDLE) || (|r_pend);
  assign dbg_state = r_state;

endmodule
